// File: rtl/id_ex_ctrl_pkg.sv
// id_ex_ctrl_pkg: opcode, ALU-op and field constants plus the ID/EX record shared by decode, ALU and branch logic
package id_ex_ctrl_pkg;
  localparam logic [3:0] OP_MOVE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NOP  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SUBI = 4'd8;
  localparam logic [3:0] OP_ANDI = 4'd9;
  localparam logic [3:0] OP_ORI  = 4'd10;
  localparam logic [3:0] OP_LW   = 4'd11;
  localparam logic [3:0] OP_SW   = 4'd12;
  localparam logic [3:0] OP_BEQ  = 4'd13;
  localparam logic [3:0] OP_JMP  = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam logic [3:0] ALU_MOVE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_NOP  = 4'b0110;
  localparam logic [3:0] ALU_ADDI = 4'b0111;
  localparam logic [3:0] ALU_SUBI = 4'b1000;
  localparam logic [3:0] ALU_ANDI = 4'b1001;
  localparam logic [3:0] ALU_ORI  = 4'b1010;
  localparam logic [3:0] ALU_BUBBLE = ALU_NOP;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 9;
  localparam int RS_HI = 8;
  localparam int RS_LO = 6;
  localparam int RT_HI = 5;
  localparam int RT_LO = 3;
  localparam int IMM_HI = 5;
  localparam int JMP_HI = 11;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [15:0] pc;
    logic        illegal;
  } idex_t;

  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_MOVE: return ALU_MOVE;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_ADDI: return ALU_ADDI;
      OP_SUBI: return ALU_SUBI;
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_LW:   return ALU_ADDI;
      OP_SW:   return ALU_ADDI;
      OP_BEQ:  return ALU_SUB;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic idex_t bubble();
    idex_t b;
    b = '0;
    b.alu_op = ALU_BUBBLE;
    return b;
  endfunction
endpackage

// File: rtl/id_ex_ctrl_decode.sv
// instr_decode: combinational instruction-to-control decode with source-register usage flags
module instr_decode
  import id_ex_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output idex_t       dec,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        uses_rd
);
  logic [3:0] op;
  assign op = instr[OP_HI:OP_LO];
  always_comb begin
    dec = '0;
    dec.valid = 1'b1;
    dec.alu_op = alu_op_of(op);
    dec.rd = instr[RD_HI:RD_LO];
    dec.rs = instr[RS_HI:RS_LO];
    dec.rt = instr[RT_HI:RT_LO];
    dec.imm = op == OP_JMP ? {4'b0, instr[JMP_HI:0]} : {{10{instr[IMM_HI]}}, instr[IMM_HI:0]};
    dec.alu_src_imm = op >= OP_ADDI && op <= OP_SW;
    dec.reg_write = (op <= OP_NOT || (op >= OP_ADDI && op <= OP_LW)) && instr[RD_HI:RD_LO] != 3'd0;
    dec.mem_read = op == OP_LW;
    dec.mem_write = op == OP_SW;
    dec.branch = op == OP_BEQ;
    dec.jump = op == OP_JMP;
    dec.illegal = op == OP_ILL;
  end
  assign uses_rs = !(op == OP_NOP || op == OP_JMP || op == OP_ILL);
  assign uses_rt = op >= OP_ADD && op <= OP_OR;
  assign uses_rd = op == OP_SW || op == OP_BEQ;
endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: decode, load-use hazard detection and ID/EX register with stall/flush bubbles
module id_ex_ctrl
  import id_ex_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc,
  input  logic        ex_flush,
  output logic        stall,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [2:0]  ex_rd,
  output logic [2:0]  ex_rs,
  output logic [2:0]  ex_rt,
  output logic [15:0] ex_imm,
  output logic        ex_alu_src_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [15:0] ex_pc,
  output logic        ex_illegal
);
  idex_t dec, idex_d, idex_q;
  logic uses_rs, uses_rt, uses_rd, hazard;
  instr_decode u_dec (
    .instr   (if_instr),
    .dec     (dec),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .uses_rd (uses_rd)
  );
  // r0 never matches: a load into r0 has no observable result
  assign hazard = if_valid && idex_q.valid && idex_q.mem_read && idex_q.rd != 3'd0 &&
                  ((uses_rs && dec.rs == idex_q.rd) || (uses_rt && dec.rt == idex_q.rd) ||
                   (uses_rd && dec.rd == idex_q.rd));
  assign stall = hazard && !ex_flush;
  always_comb begin
    idex_d = dec;
    idex_d.pc = if_pc;
    idex_d = (ex_flush || hazard || !if_valid) ? bubble() : idex_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idex_q <= bubble();
    else idex_q <= idex_d;
  assign ex_valid       = idex_q.valid;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_rd          = idex_q.rd;
  assign ex_rs          = idex_q.rs;
  assign ex_rt          = idex_q.rt;
  assign ex_imm         = idex_q.imm;
  assign ex_alu_src_imm = idex_q.alu_src_imm;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_branch      = idex_q.branch;
  assign ex_jump        = idex_q.jump;
  assign ex_pc          = idex_q.pc;
  assign ex_illegal     = idex_q.illegal;
endmodule

// File: tb/tb_id_ex_ctrl.sv
// tb_id_ex_ctrl: directed self-checking bench for decode, load-use stalls, flush and reset
module tb_id_ex_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, if_valid = 1'b0, ex_flush = 1'b0;
  logic [15:0] if_instr = 16'h0, if_pc = 16'h0;
  logic stall, ex_valid, ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write;
  logic ex_branch, ex_jump, ex_illegal;
  logic [3:0] ex_alu_op;
  logic [2:0] ex_rd, ex_rs, ex_rt;
  logic [15:0] ex_imm, ex_pc;
  int n_chk = 0, n_fail = 0;

  id_ex_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc; ex_flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) tick();
    n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    n_chk++; if (ex_alu_op !== 4'b0110) begin n_fail++; $display("FAIL reset_alu_op got %b want 0110", ex_alu_op); end
    n_chk++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal, ex_pc, ex_imm} !== '0) begin n_fail++; $display("FAIL reset_ctrl got nonzero"); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    drive(1'b1, 16'h1298, 16'h0010, 1'b0);
    tick();
    n_chk++; if ({ex_valid, ex_alu_op, ex_rd, ex_rs, ex_rt, ex_reg_write, ex_alu_src_imm} !== {1'b1, 4'b0001, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_fields got v%0b op%b rd%0d rs%0d rt%0d rw%0b imm%0b", ex_valid, ex_alu_op, ex_rd, ex_rs, ex_rt, ex_reg_write, ex_alu_src_imm); end
    n_chk++; if (ex_pc !== 16'h0010) begin n_fail++; $display("FAIL add_pc got %h want 0010", ex_pc); end
  endtask

  task automatic test_itype();
    drive(1'b1, 16'h747F, 16'h0012, 1'b0);
    tick();
    n_chk++; if ({ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write, ex_rd, ex_rs} !== {16'hFFFF, 4'b0111, 1'b1, 1'b1, 3'd2, 3'd1}) begin n_fail++; $display("FAIL addi got imm%h op%b src%0b rw%0b", ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write); end
    drive(1'b1, 16'hA045, 16'h0014, 1'b0);
    tick();
    n_chk++; if ({ex_alu_op, ex_reg_write, ex_imm, ex_alu_src_imm} !== {4'b1010, 1'b0, 16'h0005, 1'b1}) begin n_fail++; $display("FAIL ori_r0 got op%b rw%0b imm%h", ex_alu_op, ex_reg_write, ex_imm); end
    drive(1'b1, 16'hD283, 16'h0016, 1'b0);
    tick();
    n_chk++; if ({ex_branch, ex_alu_op, ex_imm, ex_reg_write, ex_alu_src_imm} !== {1'b1, 4'b0010, 16'h0003, 1'b0, 1'b0}) begin n_fail++; $display("FAIL beq got br%0b op%b imm%h", ex_branch, ex_alu_op, ex_imm); end
    drive(1'b1, 16'hE123, 16'h0018, 1'b0);
    tick();
    n_chk++; if ({ex_jump, ex_alu_op, ex_imm, ex_reg_write} !== {1'b1, 4'b0110, 16'h0123, 1'b0}) begin n_fail++; $display("FAIL jmp got j%0b op%b imm%h", ex_jump, ex_alu_op, ex_imm); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 16'hB280, 16'h0020, 1'b0);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_nostall got %0b want 0", stall); end
    tick();
    n_chk++; if ({ex_mem_read, ex_alu_op, ex_alu_src_imm, ex_reg_write, ex_rd} !== {1'b1, 4'b0111, 1'b1, 1'b1, 3'd1}) begin n_fail++; $display("FAIL lw_fields got mr%0b op%b rd%0d", ex_mem_read, ex_alu_op, ex_rd); end
    drive(1'b1, 16'h1660, 16'h0022, 1'b0);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0b want 1", stall); end
    tick();
    n_chk++; if ({ex_valid, ex_alu_op, ex_mem_read} !== {1'b0, 4'b0110, 1'b0}) begin n_fail++; $display("FAIL lu_bubble got v%0b op%b", ex_valid, ex_alu_op); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_one got %0b want 0", stall); end
    tick();
    n_chk++; if ({ex_valid, ex_alu_op, ex_rd, ex_rs, ex_pc} !== {1'b1, 4'b0001, 3'd3, 3'd1, 16'h0022}) begin n_fail++; $display("FAIL lu_issue got v%0b op%b rd%0d rs%0d", ex_valid, ex_alu_op, ex_rd, ex_rs); end
    drive(1'b1, 16'hB280, 16'h0030, 1'b0);
    tick();
    drive(1'b1, 16'h1760, 16'h0032, 1'b0);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL indep_stall got %0b want 0", stall); end
    drive(1'b1, 16'h1660, 16'h0032, 1'b0);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rt_rs_stall got %0b want 1", stall); end
    drive(1'b1, 16'hC280, 16'h0032, 1'b0);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_rd_stall got %0b want 1", stall); end
    drive(1'b0, 16'h1660, 16'h0032, 1'b0);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL invalid_nostall got %0b want 0", stall); end
    tick();
    n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL invalid_bubble got %0b want 0", ex_valid); end
    drive(1'b1, 16'hB080, 16'h0040, 1'b0);
    tick();
    n_chk++; if ({ex_mem_read, ex_reg_write} !== 2'b10) begin n_fail++; $display("FAIL lw_r0 got mr%0b rw%0b", ex_mem_read, ex_reg_write); end
    drive(1'b1, 16'h1620, 16'h0042, 1'b0);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_nostall got %0b want 0", stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'hB280, 16'h0050, 1'b0);
    tick();
    drive(1'b1, 16'hB240, 16'h0052, 1'b0);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %0b want 1", stall); end
    tick();
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_one got %0b want 0", stall); end
    tick();
    n_chk++; if ({ex_valid, ex_mem_read, ex_rd, ex_rs} !== {1'b1, 1'b1, 3'd1, 3'd1}) begin n_fail++; $display("FAIL b2b_issue got v%0b mr%0b rd%0d rs%0d", ex_valid, ex_mem_read, ex_rd, ex_rs); end
  endtask

  task automatic test_flush();
    drive(1'b1, 16'hB280, 16'h0060, 1'b0);
    tick();
    drive(1'b1, 16'h1660, 16'h0062, 1'b1);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_stall got %0b want 0", stall); end
    tick();
    n_chk++; if ({ex_valid, ex_alu_op} !== {1'b0, 4'b0110}) begin n_fail++; $display("FAIL flush_hazard_bubble got v%0b op%b", ex_valid, ex_alu_op); end
    drive(1'b1, 16'h2298, 16'h0064, 1'b1);
    tick();
    n_chk++; if ({ex_valid, ex_alu_op, ex_reg_write} !== {1'b0, 4'b0110, 1'b0}) begin n_fail++; $display("FAIL flush_sub got v%0b op%b", ex_valid, ex_alu_op); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 16'hF000, 16'h0070, 1'b0);
    tick();
    n_chk++; if ({ex_valid, ex_illegal, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump} !== {1'b1, 1'b1, 4'b0110, 5'b0}) begin n_fail++; $display("FAIL illegal got v%0b il%0b op%b", ex_valid, ex_illegal, ex_alu_op); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 16'hB280, 16'h0080, 1'b0);
    tick();
    drive(1'b1, 16'h1660, 16'h0082, 1'b0);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall got %0b want 1", stall); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({ex_valid, ex_alu_op, ex_mem_read, stall} !== {1'b0, 4'b0110, 1'b0, 1'b0}) begin n_fail++; $display("FAIL async_rst got v%0b op%b st%0b", ex_valid, ex_alu_op, stall); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_chk++; if ({ex_valid, ex_alu_op, ex_rd} !== {1'b1, 4'b0001, 3'd3}) begin n_fail++; $display("FAIL post_rst got v%0b op%b rd%0d", ex_valid, ex_alu_op, ex_rd); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
